// File: rtl/ddr5_req_queue_mapper.sv
// rtl/ddr5_req_queue_mapper.sv - age-ordered DDR5 request queue with address mapping and auto-retire
module ddr5_req_queue_mapper #(
    parameter int ADDR_W   = 34,
    parameter int DEPTH    = 16,
    parameter int TP_W     = 8,
    parameter int MAP_MODE = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [1:0]               req_op,
    input  logic                     upd_valid,
    input  logic [$clog2(DEPTH)-1:0] upd_idx,
    input  logic [1:0]               upd_status,
    input  logic [TP_W-1:0]          upd_tp,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [1:0]               rd_op,
    output logic [1:0]               rd_status,
    output logic [TP_W-1:0]          rd_tp,
    output logic                     rd_channel,
    output logic [2:0]               rd_bg,
    output logic [1:0]               rd_bank,
    output logic [15:0]              rd_row,
    output logic [9:0]               rd_col,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pop_valid,
    output logic [ADDR_W-1:0]        pop_addr,
    output logic [31:0]              retire_cnt
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] ST_PROCESSED = 2'd2;

    typedef struct packed {
        logic        channel;
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } map_t;

    logic [ADDR_W-1:0] addr_q   [DEPTH];
    logic [1:0]        op_q     [DEPTH];
    logic [1:0]        status_q [DEPTH];
    logic [TP_W-1:0]   tp_q     [DEPTH];
    map_t              map_q    [DEPTH];

    logic [IW-1:0]     head_q, head_d, tail, upd_slot, rd_slot;
    logic [IW:0]       count_q, count_d;
    logic              pop_valid_q;
    logic [ADDR_W-1:0] pop_addr_q;
    logic [31:0]       retire_q;
    logic              do_push, do_pop, do_upd;
    logic [DEPTH-1:0]  live;
    map_t              map_d;

    always_comb begin
        map_d.row     = req_addr[33:18];
        map_d.col     = {req_addr[17:12], req_addr[5:2]};
        map_d.bank    = req_addr[11:10];
        map_d.bg      = req_addr[9:7];
        map_d.channel = req_addr[6] ^ ((MAP_MODE == 1) && req_addr[18]);
    end

    assign tail      = head_q + count_q[IW-1:0];
    assign upd_slot  = head_q + upd_idx;
    assign rd_slot   = head_q + rd_idx;
    assign req_ready = count_q < (IW+1)'(DEPTH);
    assign do_push   = req_valid && req_ready;
    assign do_pop    = (count_q != '0) && (status_q[head_q] == ST_PROCESSED) && (tp_q[head_q] == '0);
    // An update aimed at the entry retiring this edge is dropped.
    assign do_upd    = upd_valid && ({1'b0, upd_idx} < count_q) && (upd_status != 2'd3)
                       && !(do_pop && (upd_idx == '0));
    assign head_d    = do_pop ? head_q + IW'(1) : head_q;
    assign count_d   = count_q + (IW+1)'(do_push) - (IW+1)'(do_pop);

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            live[s] = ({1'b0, IW'(s) - head_q} < count_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_addr_q  <= '0;
            retire_q    <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                addr_q[s]   <= '0;
                op_q[s]     <= '0;
                status_q[s] <= '0;
                tp_q[s]     <= '0;
                map_q[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (live[s]) begin
                    if (do_upd && (upd_slot == IW'(s))) begin
                        status_q[s] <= upd_status;
                        tp_q[s]     <= upd_tp;
                    end else if (tp_q[s] != '0) begin
                        tp_q[s] <= tp_q[s] - 1'b1;
                    end
                end
            end
            if (do_push) begin
                addr_q[tail]   <= req_addr;
                op_q[tail]     <= req_op;
                status_q[tail] <= '0;
                tp_q[tail]     <= '0;
                map_q[tail]    <= map_d;
            end
            head_q      <= head_d;
            count_q     <= count_d;
            pop_valid_q <= do_pop;
            if (do_pop) begin
                pop_addr_q <= addr_q[head_q];
            end
            retire_q <= retire_q + 32'(do_pop);
        end
    end

    assign rd_valid   = {1'b0, rd_idx} < count_q;
    assign rd_op      = rd_valid ? op_q[rd_slot]          : '0;
    assign rd_status  = rd_valid ? status_q[rd_slot]      : '0;
    assign rd_tp      = rd_valid ? tp_q[rd_slot]          : '0;
    assign rd_channel = rd_valid ? map_q[rd_slot].channel : 1'b0;
    assign rd_bg      = rd_valid ? map_q[rd_slot].bg      : '0;
    assign rd_bank    = rd_valid ? map_q[rd_slot].bank    : '0;
    assign rd_row     = rd_valid ? map_q[rd_slot].row     : '0;
    assign rd_col     = rd_valid ? map_q[rd_slot].col     : '0;
    assign count      = count_q;
    assign pop_valid  = pop_valid_q;
    assign pop_addr   = pop_addr_q;
    assign retire_cnt = retire_q;
endmodule

// File: tb/tb_ddr5_req_queue_mapper.sv
// tb/tb_ddr5_req_queue_mapper.sv - queue-model checked bench for ddr5_req_queue_mapper
module tb_ddr5_req_queue_mapper;
    localparam int ADDR_W = 34;
    localparam int DEPTH  = 16;
    localparam int TP_W   = 8;
    localparam int IW     = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [1:0]        req_op = '0;
    logic              upd_valid = 1'b0;
    logic [IW-1:0]     upd_idx = '0;
    logic [1:0]        upd_status = '0;
    logic [TP_W-1:0]   upd_tp = '0;
    logic [IW-1:0]     rd_idx = '0;

    logic              req_ready, rd_valid, rd_channel, pop_valid;
    logic [1:0]        rd_op, rd_status, rd_bank;
    logic [TP_W-1:0]   rd_tp;
    logic [2:0]        rd_bg;
    logic [15:0]       rd_row;
    logic [9:0]        rd_col;
    logic [IW:0]       count;
    logic [ADDR_W-1:0] pop_addr;
    logic [31:0]       retire_cnt;

    logic              h_req_ready, h_rd_valid, h_rd_channel, h_pop_valid;
    logic [1:0]        h_rd_op, h_rd_status, h_rd_bank;
    logic [TP_W-1:0]   h_rd_tp;
    logic [2:0]        h_rd_bg;
    logic [15:0]       h_rd_row;
    logic [9:0]        h_rd_col;
    logic [IW:0]       h_count;
    logic [ADDR_W-1:0] h_pop_addr;
    logic [31:0]       h_retire_cnt;

    ddr5_req_queue_mapper #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TP_W(TP_W), .MAP_MODE(0)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_op(req_op), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_status(upd_status), .upd_tp(upd_tp), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_op(rd_op), .rd_status(rd_status), .rd_tp(rd_tp), .rd_channel(rd_channel),
        .rd_bg(rd_bg), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col), .count(count),
        .pop_valid(pop_valid), .pop_addr(pop_addr), .retire_cnt(retire_cnt));

    ddr5_req_queue_mapper #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TP_W(TP_W), .MAP_MODE(1)) u_dut_h (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(h_req_ready),
        .req_addr(req_addr), .req_op(req_op), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_status(upd_status), .upd_tp(upd_tp), .rd_idx(rd_idx), .rd_valid(h_rd_valid),
        .rd_op(h_rd_op), .rd_status(h_rd_status), .rd_tp(h_rd_tp), .rd_channel(h_rd_channel),
        .rd_bg(h_rd_bg), .rd_bank(h_rd_bank), .rd_row(h_rd_row), .rd_col(h_rd_col), .count(h_count),
        .pop_valid(h_pop_valid), .pop_addr(h_pop_addr), .retire_cnt(h_retire_cnt));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [33:0] m_addr[$];
    logic [1:0]  m_op[$];
    logic [1:0]  m_st[$];
    int          m_tp[$];
    logic        exp_pv = 1'b0;
    logic [33:0] exp_pa = '0;
    logic [31:0] exp_ret = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        logic v;
        logic [33:0] a;
        n = m_addr.size();
        v = (int'(rd_idx) < n);
        a = v ? m_addr[rd_idx] : 34'd0;
        chk("req_ready", req_ready, n < DEPTH);
        chk("count", count, n);
        chk("h_count", h_count, n);
        chk("rd_valid", rd_valid, v);
        chk("rd_op", rd_op, v ? m_op[rd_idx] : 2'd0);
        chk("rd_status", rd_status, v ? m_st[rd_idx] : 2'd0);
        chk("rd_tp", rd_tp, v ? m_tp[rd_idx] : 0);
        chk("rd_row", rd_row, (a >> 18) & 34'hFFFF);
        chk("rd_col", rd_col, ((a >> 12) & 34'h3F) * 16 + ((a >> 2) & 34'hF));
        chk("rd_bank", rd_bank, (a >> 10) & 34'h3);
        chk("rd_bg", rd_bg, (a >> 7) & 34'h7);
        chk("rd_channel", rd_channel, (a >> 6) & 34'h1);
        chk("h_rd_channel", h_rd_channel, ((a >> 6) ^ (a >> 18)) & 34'h1);
        chk("pop_valid", pop_valid, exp_pv);
        if (exp_pv) chk("pop_addr", pop_addr, exp_pa);
        chk("retire_cnt", retire_cnt, exp_ret);
    endtask

    task automatic model_step(input logic rv, input logic [33:0] ra, input logic [1:0] ro,
                              input logic uv, input int ui, input logic [1:0] us, input int ut);
        int n;
        bit pop, push, upd;
        n    = m_addr.size();
        pop  = (n > 0) && (m_st[0] == 2'd2) && (m_tp[0] == 0);
        push = rv && (n < DEPTH);
        upd  = uv && (ui < n) && (us != 2'd3) && !(pop && ui == 0);
        for (int i = 0; i < n; i++) begin
            if (upd && i == ui) begin
                m_st[i] = us;
                m_tp[i] = ut;
            end else if (m_tp[i] > 0) begin
                m_tp[i] = m_tp[i] - 1;
            end
        end
        exp_pv = pop;
        if (pop) begin
            exp_pa  = m_addr[0];
            exp_ret = exp_ret + 1;
            void'(m_addr.pop_front());
            void'(m_op.pop_front());
            void'(m_st.pop_front());
            void'(m_tp.pop_front());
        end
        if (push) begin
            m_addr.push_back(ra);
            m_op.push_back(ro);
            m_st.push_back(2'd0);
            m_tp.push_back(0);
        end
    endtask

    task automatic model_clear();
        m_addr.delete();
        m_op.delete();
        m_st.delete();
        m_tp.delete();
        exp_pv  = 1'b0;
        exp_pa  = '0;
        exp_ret = '0;
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clock);
        model_step(req_valid, req_addr, req_op, upd_valid, int'(upd_idx), upd_status, int'(upd_tp));
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        upd_valid = 1'b0;
        reset = 1'b1;
        model_clear();
        #1;
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_push(input logic [33:0] a, input logic [1:0] op);
        req_valid = 1'b1;
        req_addr  = a;
        req_op    = op;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_upd(input int idx, input logic [1:0] st, input int tp);
        upd_valid  = 1'b1;
        upd_idx    = IW'(idx);
        upd_status = st;
        upd_tp     = TP_W'(tp);
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        int pprob, n;
        #2;
        do_reset();

        // single push, mapping of a known address
        rd_idx = '0;
        do_push(34'h2_8004_0E44, 2'd1);
        #1;
        chk("t1_channel", rd_channel, 1);
        chk("t1_bg", rd_bg, 4);
        chk("t1_bank", rd_bank, 3);
        chk("t1_row", rd_row, 16'hA001);
        chk("t1_col", rd_col, 10'h001);
        chk("t1_status", rd_status, 0);
        chk("t1_count", count, 1);
        chk("t1_hash_channel", h_rd_channel, 0);

        // head retires four edges after the update that arms it
        do_push(34'h1_2345_6788, 2'd0);
        do_push(34'h0_0000_0040, 2'd2);
        do_upd(0, 2'd2, 3);
        repeat (3) tick();
        chk("t2_no_early_pop", pop_valid, 0);
        chk("t2_count_before", count, 3);
        tick();
        chk("t2_pop_valid", pop_valid, 1);
        chk("t2_pop_addr", pop_addr, 34'h2_8004_0E44);
        chk("t2_retire", retire_cnt, 1);
        chk("t2_count", count, 2);

        // processed non-head entry waits for the head
        do_upd(1, 2'd2, 0);
        tick();
        chk("t4_blocked", pop_valid, 0);
        chk("t4_count_blocked", count, 2);
        do_upd(0, 2'd2, 0);
        chk("t4_armed", pop_valid, 0);
        tick();
        chk("t4_pop1", pop_valid, 1);
        chk("t4_ret1", retire_cnt, 2);
        tick();
        chk("t4_pop2", pop_valid, 1);
        chk("t4_ret2", retire_cnt, 3);
        chk("t4_empty", count, 0);

        // pop, push and head update on one edge
        do_push(34'h0_1111_1110, 2'd0);
        do_push(34'h3_FFFF_FFFC, 2'd1);
        do_push(34'h0_0ABC_DEF4, 2'd2);
        do_upd(1, 2'd1, 5);
        do_upd(0, 2'd2, 0);
        req_valid = 1'b1;
        req_addr  = 34'h1_0000_0004;
        upd_valid = 1'b1;
        upd_idx   = '0;
        upd_status = 2'd0;
        upd_tp    = 8'd9;
        tick();
        req_valid = 1'b0;
        upd_valid = 1'b0;
        rd_idx = '0;
        #1;
        chk("t5_count", count, 3);
        chk("t5_pop", pop_valid, 1);
        chk("t5_pop_addr", pop_addr, 34'h0_1111_1110);
        chk("t5_head_status", rd_status, 1);
        chk("t5_head_tp", rd_tp, 3);
        chk("t5_retire", retire_cnt, 4);

        // full queue, refused push, pop while full, wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push(34'({$urandom(), $urandom()}), 2'($urandom()));
        chk("t3_not_ready", req_ready, 0);
        chk("t3_full", count, 16);
        req_valid = 1'b1;
        req_addr  = 34'h0_DEAD_BEE0;
        tick();
        chk("t3_refused", count, 16);
        upd_valid = 1'b1; upd_idx = '0; upd_status = 2'd2; upd_tp = '0;
        tick();
        upd_valid = 1'b0;
        chk("t3_still_full", count, 16);
        tick();
        chk("t3_pop_no_push", count, 15);
        chk("t3_pop_seen", pop_valid, 1);
        tick();
        req_valid = 1'b0;
        chk("t3_refill", count, 16);
        rd_idx = 4'd15;
        #1;
        chk("t3_tail_addr_row", rd_row, 16'h37AB);

        // randomized traffic
        for (int blk = 0; blk < 6; blk++) begin
            pprob = (blk * 37) % 90 + 10;
            for (int c = 0; c < 500; c++) begin
                n = m_addr.size();
                req_valid  = ($urandom() % 100) < pprob;
                req_addr   = 34'({$urandom(), $urandom()});
                req_op     = 2'($urandom());
                upd_valid  = $urandom() % 2;
                if ($urandom() % 3 == 0) upd_idx = '0;
                else if ($urandom() % 3 == 0 || n == 0) upd_idx = IW'($urandom());
                else upd_idx = IW'($urandom() % n);
                upd_status = ($urandom() % 2) ? 2'd2 : 2'($urandom());
                upd_tp     = ($urandom() % 8 == 0) ? TP_W'($urandom()) : TP_W'($urandom() % 4);
                rd_idx     = IW'($urandom());
                tick();
            end
        end
        req_valid = 1'b0;
        upd_valid = 1'b0;

        // asynchronous reset with entries queued and a pop pending
        for (int k = 0; k < 400 && m_addr.size() > 0; k++) do_upd(0, 2'd2, 0);
        for (int i = 0; i < 5; i++) do_push(34'({$urandom(), $urandom()}), 2'd0);
        do_upd(0, 2'd2, 0);
        rd_idx = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
        do_push(34'h0_0000_1234, 2'd3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr5_req_queue_mapper.md
Name: ddr5_req_queue_mapper

Overview:
- Parametrised, synthesizable successor to the scheduler's software request queue.
- Accepts CPU requests, maps each address into DDR5 channel, bank group, bank, row and column fields, and holds up to DEPTH entries in age order.
- Each entry carries a status and a countdown timer; the oldest entry retires automatically once it is PROCESSED and its timer has reached zero.
- Sits between the trace-request front end and the DRAM command scheduler. The scheduler inspects entries by logical index and updates them.

Parameters:
- ADDR_W, 34, request address width. Must be at least 34; only bits [33:0] are mapped.
- DEPTH, 16, queue entries. Power of 2, at least 2.
- TP_W, 8, width of the per-entry timing countdown.
- MAP_MODE, 0, address map select: 0 = linear, 1 = channel hashed with row LSB.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  new request present.
- req_ready  out  1  queue can accept a request (count < DEPTH).
- req_addr  in  ADDR_W  request byte address.
- req_op  in  2  0 = read, 1 = write, 2 = ifetch, 3 = reserved (stored as given).
- upd_valid  in  1  scheduler entry update strobe.
- upd_idx  in  log2(DEPTH)  logical index of entry to update (0 = oldest).
- upd_status  in  2  new status: 0 = PENDING, 1 = ACTIVE, 2 = PROCESSED.
- upd_tp  in  TP_W  new timer value.
- rd_idx  in  log2(DEPTH)  logical index to inspect.
- rd_valid  out  1  rd_idx < count.
- rd_op  out  2  op of inspected entry.
- rd_status  out  2  status of inspected entry.
- rd_tp  out  TP_W  timer of inspected entry.
- rd_channel  out  1  mapped channel.
- rd_bg  out  3  mapped bank group.
- rd_bank  out  2  mapped bank.
- rd_row  out  16  mapped row.
- rd_col  out  10  mapped column {col_high, col_low}.
- count  out  log2(DEPTH)+1  occupied entries.
- pop_valid  out  1  one-cycle pulse: an entry retired on the previous edge.
- pop_addr  out  ADDR_W  address of the retired entry.
- retire_cnt  out  32  total retired entries; wraps modulo 2^32.

Behaviour:
- Storage is a circular buffer with a head pointer. Logical index i maps to physical slot (head+i) mod DEPTH.
- All rd_* outputs are combinational from rd_idx. When rd_idx >= count, all rd_* outputs are 0.
- Mapping is computed combinationally at push and stored with the entry. Field layout:
  - row = a[33:18]
  - col_high = a[17:12]
  - bank = a[11:10]
  - bg = a[9:7]
  - channel = a[6]
  - col_low = a[5:2]
  - a[1:0] is ignored.
  - MAP_MODE 1 only: channel = a[6] ^ a[18].
- Push: when req_valid && req_ready at an edge, the entry is written at the tail with status PENDING and tp = 0. It is visible from the next cycle. There is no bypass: req_ready depends only on pre-edge count, so a full queue refuses even if a pop occurs on the same edge.
- Timers: at every edge, each valid entry's tp decrements by 1, saturating at 0, unless that entry is written by an update on the same edge.
- Update: upd_valid with upd_idx < pre-edge count writes upd_status and loads upd_tp exactly, with no decrement that cycle.
  - upd_idx >= count: update ignored.
  - upd_status = 3: update ignored.
  - upd_idx refers to the pre-edge ordering.
- Pop: evaluated on pre-edge state. If count > 0, head status == PROCESSED and head tp == 0, then at the edge:
  - head advances and count decrements;
  - pop_valid = 1 and pop_addr = head address on the following cycle;
  - retire_cnt increments.
  - Only the head may retire. A processed non-head entry waits until it reaches the head.
- Update and pop of the same entry on the same edge: pop wins and the update is dropped. An update to any other entry lands on that entry at its post-pop position.
- Push and pop on the same edge: both take effect and count is unchanged.
- The tail wraps from DEPTH-1 to 0, and so does the head.
- Reset, which may be asserted mid-operation, asynchronously clears all entries, pointers, count, pop_valid, pop_addr and retire_cnt. Reset values:
  - req_ready = 1
  - every other output = 0

Test Plan:
- Reset, push addr 0x2_8004_0E44: rd_idx 0 reads channel 1, bg 4, bank 3, row 0xA001, col {col_high 0x00, col_low 0x1} = 0x001, status 0, count 1. With MAP_MODE 1, channel 0.
- Push 3 entries; update idx0 to status 2, tp 3 → head retires exactly 4 edges later. pop_valid pulses once with the idx0 address, retire_cnt = 1, count = 2.
- Push 16 entries → req_ready = 0 and a 17th push is refused. Retire the head while req_valid is held → no push that edge; push is accepted on the next edge, tail wraps to slot 0, count returns to 16.
- Update idx1 to PROCESSED with tp 0 while the head is PENDING → no pop. Later set the head PROCESSED with tp 0 → two consecutive pops, retire_cnt += 2.
- Same edge: head pops, push arrives, and an update targets idx0 → update dropped. Count unchanged, and the new head (old idx1) keeps its prior status.
- Assert reset with 5 entries queued and a pop pending → count 0, pop_valid 0, retire_cnt 0, req_ready 1 immediately, without waiting for a clock edge.
